// File: rtl/next_pc_unit.sv
// next_pc_unit: registered fetch-address sequencer with IDLE/RUN/HALTED control,
// branch redirect, one-cycle flush pulse and saturating taken-redirect counter.
module next_pc_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] StartPC,
  input  logic        Run,
  input  logic        Stall,
  input  logic        Halt,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        ALUZero,
  input  logic [63:0] SignExtImm64,
  output logic [63:0] CurrentPC,
  output logic        FetchValid,
  output logic        Flush,
  output logic [15:0] TakenCount,
  output logic [1:0]  State
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10} state_t;
  state_t      r_state;
  logic [63:0] r_pc;
  logic        r_valid;
  logic        r_flush;
  logic [15:0] r_cnt;
  logic        w_taken;
  logic        w_adv;
  logic [63:0] w_target;
  logic [63:0] w_seq;
  assign w_taken   = Uncondbranch | (Branch & ALUZero);
  assign w_adv     = !Halt && !Stall;
  assign w_target  = r_pc + SignExtImm64;
  assign w_seq     = r_pc + 64'd4;
  assign CurrentPC  = r_pc;
  assign FetchValid = r_valid;
  assign Flush      = r_flush;
  assign TakenCount = r_cnt;
  assign State      = r_state;
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pc    <= StartPC;
          r_valid <= Run;
          r_flush <= 1'b0;
          r_state <= Run ? RUN : IDLE;
        end
        RUN: begin
          r_state <= Halt ? HALTED : RUN;
          r_valid <= !Halt;
          r_flush <= w_adv && w_taken;
          if (w_adv) begin
            r_pc  <= w_taken ? w_target : w_seq;
            r_cnt <= (w_taken && r_cnt != 16'hFFFF) ? r_cnt + 16'd1 : r_cnt;
          end
        end
        HALTED: begin
          r_valid <= 1'b0;
          r_flush <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_pc    <= StartPC;
          r_valid <= 1'b0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: table-driven directed checks plus hand-written reset/wrap/saturation sequences.
module tb_next_pc_unit;
  logic        CLK, Reset, Run, Stall, Halt, Branch, Uncondbranch, ALUZero;
  logic [63:0] StartPC, SignExtImm64, CurrentPC;
  logic        FetchValid, Flush;
  logic [15:0] TakenCount;
  logic [1:0]  State;
  int n_chk, n_pass;
  typedef struct {
    logic        stall, halt, br, ub, zero;
    logic [63:0] imm, pc;
    logic        flush, valid;
    logic [15:0] cnt;
    logic [1:0]  st;
  } vec_t;
  vec_t v[14];
  next_pc_unit dut (
    .CLK(CLK), .Reset(Reset), .StartPC(StartPC), .Run(Run), .Stall(Stall), .Halt(Halt),
    .Branch(Branch), .Uncondbranch(Uncondbranch), .ALUZero(ALUZero), .SignExtImm64(SignExtImm64),
    .CurrentPC(CurrentPC), .FetchValid(FetchValid), .Flush(Flush), .TakenCount(TakenCount), .State(State)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic chk_all(input string n, input logic [63:0] pc, input logic fl, input logic va,
                         input logic [15:0] cnt, input logic [1:0] st);
    chk({n, "_pc"}, CurrentPC, pc);
    chk({n, "_flush"}, {63'd0, Flush}, {63'd0, fl});
    chk({n, "_valid"}, {63'd0, FetchValid}, {63'd0, va});
    chk({n, "_cnt"}, {48'd0, TakenCount}, {48'd0, cnt});
    chk({n, "_state"}, {62'd0, State}, {62'd0, st});
  endtask
  task automatic step(input logic s, h, b, u, z, input logic [63:0] imm);
    Stall = s; Halt = h; Branch = b; Uncondbranch = u; ALUZero = z; SignExtImm64 = imm;
    @(posedge CLK);
    #1;
  endtask
  task automatic start(input logic [63:0] spc);
    Reset = 1'b1; Run = 1'b0; StartPC = spc;
    #2 Reset = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    Run = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    Run = 1'b0;
  endtask
  initial begin
    n_chk = 0; n_pass = 0;
    Run = 0; Stall = 0; Halt = 0; Branch = 0; Uncondbranch = 0; ALUZero = 0;
    SignExtImm64 = 0; StartPC = 64'h1000; Reset = 1'b1;
    v[0]  = '{0,0,0,0,0, 64'h0,                  64'h1004, 0, 1, 16'd0, 2'b01};
    v[1]  = '{0,0,0,0,0, 64'h0,                  64'h1008, 0, 1, 16'd0, 2'b01};
    v[2]  = '{0,0,1,0,1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1000, 1, 1, 16'd1, 2'b01};
    v[3]  = '{0,0,0,0,0, 64'h0,                  64'h1004, 0, 1, 16'd1, 2'b01};
    v[4]  = '{0,0,0,0,0, 64'h0,                  64'h1008, 0, 1, 16'd1, 2'b01};
    v[5]  = '{0,0,1,0,0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100C, 0, 1, 16'd1, 2'b01};
    v[6]  = '{1,0,0,1,0, 64'h40,                 64'h100C, 0, 1, 16'd1, 2'b01};
    v[7]  = '{1,0,0,1,0, 64'h40,                 64'h100C, 0, 1, 16'd1, 2'b01};
    v[8]  = '{0,0,0,1,0, 64'h40,                 64'h104C, 1, 1, 16'd2, 2'b01};
    v[9]  = '{0,0,0,1,0, 64'h10,                 64'h105C, 1, 1, 16'd3, 2'b01};
    v[10] = '{0,0,1,1,0, 64'h4,                  64'h1060, 1, 1, 16'd4, 2'b01};
    v[11] = '{0,0,0,0,0, 64'h0,                  64'h1064, 0, 1, 16'd4, 2'b01};
    v[12] = '{0,0,0,0,1, 64'h100,                64'h1068, 0, 1, 16'd4, 2'b01};
    v[13] = '{0,1,0,1,0, 64'h40,                 64'h1068, 0, 0, 16'd4, 2'b10};
    #1 chk_all("reset", 64'h0, 0, 0, 16'd0, 2'b00);
    #2 Reset = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    chk_all("idle", 64'h1000, 0, 0, 16'd0, 2'b00);
    Run = 1'b1;
    step(0, 0, 1, 1, 1, 64'h40);
    chk_all("run_entry", 64'h1000, 0, 1, 16'd0, 2'b01);
    Run = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(v[i].stall, v[i].halt, v[i].br, v[i].ub, v[i].zero, v[i].imm);
      chk_all($sformatf("v%0d", i), v[i].pc, v[i].flush, v[i].valid, v[i].cnt, v[i].st);
    end
    Run = 1'b1;
    step(0, 0, 0, 1, 0, 64'h40);
    chk_all("halt_run_ignored", 64'h1068, 0, 0, 16'd4, 2'b10);
    Run = 1'b0;
    #2 Reset = 1'b1;
    #1 chk_all("async_reset", 64'h0, 0, 0, 16'd0, 2'b00);
    step(0, 0, 0, 0, 0, 0);
    #2 Reset = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    chk_all("post_reset_idle", 64'h1000, 0, 0, 16'd0, 2'b00);
    Run = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    Run = 1'b0;
    step(0, 0, 0, 1, 0, 64'h20);
    chk_all("redirect_pre_reset", 64'h1020, 1, 1, 16'd1, 2'b01);
    Reset = 1'b1;
    #1 chk_all("reset_mid_run", 64'h0, 0, 0, 16'd0, 2'b00);
    #2 Reset = 1'b0;
    step(0, 0, 0, 1, 0, 64'h20);
    chk_all("no_flush_after_reset", 64'h1000, 0, 0, 16'd0, 2'b00);
    start(64'hFFFF_FFFF_FFFF_FFFC);
    chk_all("wrap_start", 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 16'd0, 2'b01);
    step(0, 0, 0, 0, 0, 0);
    chk_all("wrap_seq", 64'h0, 0, 1, 16'd0, 2'b01);
    start(64'h0);
    for (int i = 0; i < 65534; i++) step(0, 0, 0, 1, 0, 64'h0);
    chk("cnt_65534", {48'd0, TakenCount}, 64'hFFFE);
    step(0, 0, 0, 1, 0, 64'h0);
    chk("cnt_65535", {48'd0, TakenCount}, 64'hFFFF);
    step(0, 0, 0, 1, 0, 64'h0);
    chk_all("cnt_saturated", 64'h0, 1, 1, 16'hFFFF, 2'b01);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port StartPC  input  64  program start address.
REQ-004 SHALL have port Run  input  1  leave IDLE and begin fetching.
REQ-005 SHALL have port Stall  input  1  hold PC this cycle.
REQ-006 SHALL have port Halt  input  1  stop fetching permanently until Reset.
REQ-007 SHALL have port Branch  input  1  conditional branch (CBZ-class) decoded.
REQ-008 SHALL have port Uncondbranch  input  1  unconditional branch (B-class) decoded.
REQ-009 SHALL have port ALUZero  input  1  ALU zero flag for the current instruction.
REQ-010 SHALL have port SignExtImm64  input  64  branch offset from the sign extender, already sign-extended and shifted left by 2.
REQ-011 SHALL have port CurrentPC  output  64  registered fetch address.
REQ-012 SHALL have port FetchValid  output  1  CurrentPC is a live fetch address.
REQ-013 SHALL have port Flush  output  1  one-cycle pulse after a taken redirect.
REQ-014 SHALL have port TakenCount  output  16  saturating count of taken redirects.
REQ-015 SHALL have port State  output  2  FSM state: IDLE=00, RUN=01, HALTED=10.

Function
REQ-016 SHALL define Taken = Uncondbranch | (Branch & ALUZero); Branch=Uncondbranch=1 together counts as taken.
REQ-017 SHALL compute Target = CurrentPC + SignExtImm64 and Seq = CurrentPC + 4, both modulo 2^64 (wrap, no flag).
REQ-018 IDLE: CurrentPC SHALL load StartPC every cycle; FetchValid=0; branch inputs ignored.
REQ-019 IDLE with Run=1 SHALL transition to RUN next edge, CurrentPC=StartPC at that edge, FetchValid=1 from that edge.
REQ-020 RUN SHALL apply priority Halt > Stall > Taken > sequential, evaluated per edge.
REQ-021 RUN, Halt=1: next state HALTED, CurrentPC held, FetchValid=0, Flush=0, TakenCount held.
REQ-022 RUN, Stall=1 (Halt=0): CurrentPC, TakenCount, State held; Flush=0; branch inputs ignored.
REQ-023 RUN, Taken=1: CurrentPC=Target next edge; Flush=1 for exactly that following cycle; TakenCount+1.
REQ-024 RUN, Taken=0: CurrentPC=Seq next edge; Flush=0.
REQ-025 Back-to-back taken redirects SHALL keep Flush high for each consecutive cycle following a redirect.
REQ-026 TakenCount SHALL saturate at 16'hFFFF, no wrap.
REQ-027 HALTED SHALL hold all outputs, FetchValid=0, Flush=0; only Reset exits; Run ignored.
REQ-028 All outputs SHALL be registered (no combinational input-to-output path); State 11 unreachable, SHALL recover to IDLE next edge.
REQ-029 Offsets in SignExtImm64 SHALL be used unmodified (no additional shift).

Reset
REQ-030 Reset=1 SHALL asynchronously force State=IDLE, CurrentPC=0, FetchValid=0, Flush=0, TakenCount=0, regardless of clock.
REQ-031 Reset asserted mid-RUN or mid-HALTED SHALL abandon any pending redirect; Flush SHALL not pulse after reset release.
REQ-032 After Reset deasserts, first edge SHALL load StartPC into CurrentPC (IDLE behaviour).

Verification
REQ-033 Start: StartPC=0x1000, Run pulse, 3 sequential cycles -> CurrentPC 0x1000, 0x1004, 0x1008, 0x100C; FetchValid=1; Flush=0.
REQ-034 CBZ: CurrentPC=0x1008, Branch=1, ALUZero=1, SignExtImm64=0xFFFF_FFFF_FFFF_FFF8 -> CurrentPC=0x1000, Flush=1 one cycle, TakenCount=1; ALUZero=0 instead -> 0x100C, no Flush.
REQ-035 Stall vs branch: Stall=1 with Uncondbranch=1, imm=0x40 for 2 cycles -> CurrentPC held, TakenCount unchanged; release Stall -> redirect to PC+0x40.
REQ-036 Wrap: CurrentPC=0xFFFF_FFFF_FFFF_FFFC sequential -> 0x0; TakenCount preloaded to 0xFFFF via 65535 taken redirects then one more -> stays 0xFFFF.
REQ-037 Halt/Reset: Halt=1 with Uncondbranch=1 -> State=HALTED, PC held, no Flush; Run=1 ignored; async Reset between edges -> all outputs zero immediately.
